// File: rtl/logic_fold.sv
// Multi-operand AND/OR/XOR/NAND fold with valid/ready on both sides.
// Optional out_parity port enabled by defining LOGIC_FOLD_PARITY_EN.
module logic_fold #(
   parameter  int WIDTH   = 8,
   parameter  int MAX_OPS = 16,
   localparam int CW      = $clog2(MAX_OPS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       op_sel,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    out_count,
   output logic             out_ovf
`ifdef LOGIC_FOLD_PARITY_EN
  ,output logic             out_parity
`endif
);

   localparam logic [1:0]    S_IDLE = 2'd0;
   localparam logic [1:0]    S_ACC  = 2'd1;
   localparam logic [1:0]    S_HOLD = 2'd2;
   localparam logic [CW-1:0] MAX_C  = CW'(MAX_OPS);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [1:0]       op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             run_q;
   logic [WIDTH-1:0] fold_w;
   logic [CW-1:0]    cnt_inc;
   logic             in_xfer;

   // NAND accumulates as AND; the inversion is applied only when the result is captured.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fold
      assign fold_w[gi] = (op_q == 2'b01) ? (acc_q[gi] | in_data[gi]) :
                          (op_q == 2'b10) ? (acc_q[gi] ^ in_data[gi]) :
                                            (acc_q[gi] & in_data[gi]);
   end

   assign in_ready  = run_q && (state_q != S_HOLD);
   assign out_valid = (state_q == S_HOLD);
   assign in_xfer   = in_valid && in_ready;
   assign cnt_inc   = cnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_xfer) begin
               acc_d   = in_data;
               op_d    = op_sel;
               cnt_d   = CW'(1);
               ovf_d   = 1'b0;
               state_d = (in_last || (MAX_OPS == 1)) ? S_HOLD : S_ACC;
            end
         end
         S_ACC: begin
            if (in_xfer) begin
               acc_d = fold_w;
               cnt_d = cnt_inc;
               if (in_last || (cnt_inc == MAX_C)) begin
                  state_d = S_HOLD;
                  ovf_d   = !in_last;
               end
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The result register only changes on entry to HOLD, so it stays frozen under back-pressure.
   always_comb begin
      res_d = res_q;
      if ((state_q != S_HOLD) && (state_d == S_HOLD)) begin
         res_d = (op_d == 2'b11) ? ~acc_d : acc_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         op_q    <= 2'b00;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         res_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         res_q   <= res_d;
         run_q   <= 1'b1;
      end
   end

   assign out_data  = res_q;
   assign out_count = cnt_q;
   assign out_ovf   = ovf_q;

`ifdef LOGIC_FOLD_PARITY_EN
   logic par_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= ^res_d;
      end
   end

   assign out_parity = par_q;
`endif

endmodule
